// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DELAY   = 2'd1,
    HALT_DS = 2'd2,
    HALTED  = 2'd3
  } pc_state_t;

  localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] PC_HALT_ADDR    = 32'h0000_0000;
  localparam logic [31:0] PC_INCR         = 32'd4;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect decode and target arithmetic for the instruction retiring at pc.
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = PC_HALT_ADDR
) (
  input  logic [31:0] pc,
  input  logic [31:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  input  logic        is_branch,
  input  logic        branch_cond,
  input  logic        is_jump,
  input  logic        is_jump_reg,
  output logic        redirect,
  output logic [31:0] target,
  output logic        is_halt_jump
);

  logic [31:0] pc_plus4;

  always_comb begin
    pc_plus4 = pc + PC_INCR;
    redirect = is_jump_reg | is_jump | (is_branch & branch_cond);
    target   = pc_plus4;
    // JR beats J beats a taken branch when decode flags overlap
    if (is_jump_reg)
      target = reg_target;
    else if (is_jump)
      target = {pc_plus4[31:28], jump_index, 2'b00};
    else if (is_branch && branch_cond)
      target = pc_plus4 + branch_offset;
    // only unconditional jumps can halt; a branch to HALT_ADDR is ordinary
    is_halt_jump = (is_jump_reg | is_jump) && (target == HALT_ADDR);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: sequential fetch, redirects with one delay slot,
// and halt on an unconditional jump to HALT_ADDR.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal fetch; a retiring redirect latches its target
// DELAY   | pc holds the delay slot; next retirement loads pending_target
// HALT_DS | delay slot of a halting jump; next retirement halts the core
// HALTED  | frozen at HALT_ADDR until reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = PC_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        step,
  input  logic        is_branch,
  input  logic        branch_cond,
  input  logic [31:0] branch_offset,
  input  logic        is_jump,
  input  logic [25:0] jump_index,
  input  logic        is_jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        in_delay_slot,
  output logic        active,
  output logic        ds_violation,
  output logic        misaligned
);

  pc_state_t   state, state_nxt;
  logic [31:0] pending_target, pending_nxt;
  logic [31:0] pc_nxt;
  logic        mis_nxt, dsv_nxt;
  logic        redirect, is_halt_jump;
  logic [31:0] target;

  pc_target_calc #(.HALT_ADDR(HALT_ADDR)) u_target (
    .pc            (pc),
    .branch_offset (branch_offset),
    .jump_index    (jump_index),
    .reg_target    (reg_target),
    .is_branch     (is_branch),
    .branch_cond   (branch_cond),
    .is_jump       (is_jump),
    .is_jump_reg   (is_jump_reg),
    .redirect      (redirect),
    .target        (target),
    .is_halt_jump  (is_halt_jump)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      pc             <= RESET_VECTOR;
      pending_target <= 32'h0;
      misaligned     <= 1'b0;
      ds_violation   <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      pending_target <= pending_nxt;
      misaligned     <= mis_nxt;
      ds_violation   <= dsv_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    pending_nxt = pending_target;
    mis_nxt     = misaligned;
    dsv_nxt     = 1'b0;
    unique case (state)
      RUN: begin
        if (step) begin
          pc_nxt = pc + PC_INCR;
          if (redirect) begin
            pending_nxt = target;
            state_nxt   = is_halt_jump ? HALT_DS : DELAY;
            if (target[1:0] != 2'b00) mis_nxt = 1'b1;
          end
        end
      end
      DELAY: begin
        // a redirect in the slot is dropped; the original target wins
        if (step) begin
          pc_nxt    = pending_target;
          state_nxt = RUN;
          dsv_nxt   = redirect;
        end
      end
      HALT_DS: begin
        if (step) begin
          pc_nxt    = HALT_ADDR;
          state_nxt = HALTED;
          dsv_nxt   = redirect;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    link_addr     = pc + 32'd8;
    in_delay_slot = (state == DELAY) || (state == HALT_DS);
    active        = (state != HALTED);
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the program counter for the MIPS core: sequential fetch, taken branches, J/JAL, JR/JALR, the architectural delay slot, and halt-on-jump-to-zero.
- Sits between decode and instruction fetch.
- Consumes the branch offset from the immediate sign-extension stage, which is already sign-extended and shifted left by 2 for BEQ/REGIMM. Also consumes the branch condition resolved by the ALU.
- Owns `pc`, `active` and the delay-slot bookkeeping.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset
HALT_ADDR, 32'h00000000, jump target that ends execution after its delay slot

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
step  input  1  current instruction at pc retires this cycle; all state advances only when 1
is_branch  input  1  retiring instruction is a conditional branch (BEQ/BNE/REGIMM class)
branch_cond  input  1  branch condition true (valid when is_branch)
branch_offset  input  32  sign-extended immediate, already <<2
is_jump  input  1  J/JAL
jump_index  input  26  instr_index field
is_jump_reg  input  1  JR/JALR
reg_target  input  32  rs value for JR/JALR
pc  output  32  address of instruction to fetch/execute
link_addr  output  32  pc+8, for JAL/JALR/BxxAL writeback
in_delay_slot  output  1  instruction at pc is a delay slot
active  output  1  CPU running; 0 once halted
ds_violation  output  1  one-cycle pulse: control transfer retired inside a delay slot
misaligned  output  1  sticky: a redirect target had bits[1:0] != 0

Behaviour:
- Reset (async, reset_n=0):
  - pc=RESET_VECTOR; state=RUN; pending_target=0.
  - in_delay_slot=0, active=1, ds_violation=0, misaligned=0.
  - Release is synchronous to the next clk edge.
  - Reset mid-delay-slot or mid-halt discards all pending state.
- `link_addr` = pc+8, combinational, modulo 2^32.
- Target arithmetic (all mod 2^32, wrap-around silent):
  - branch target = pc+4+branch_offset
  - jump target = {pc_plus4[31:28], jump_index, 2'b00}
  - jr target = reg_target
- Redirect priority when several qualifiers are set: is_jump_reg > is_jump > (is_branch && branch_cond).
- States:
  - RUN
    - step=0: hold everything.
    - step=1 with a redirect: latch the target into pending_target, pc<=pc+4, go to DELAY.
    - If that redirect target == HALT_ADDR and it is a jump (J/JR), go to HALT_DS instead.
    - step=1 with no redirect (including not-taken branch): pc<=pc+4.
  - DELAY (in_delay_slot=1)
    - step=0: hold.
    - step=1: pc<=pending_target, go to RUN.
    - If the delay-slot instruction is itself a redirect: ds_violation pulses for 1 cycle and the redirect is ignored; the original target wins.
  - HALT_DS (in_delay_slot=1)
    - step=1: pc<=HALT_ADDR, active<=0, go to HALTED.
    - Redirects are ignored here with ds_violation.
  - HALTED: everything frozen, step ignored, active=0; leave only via reset.
- Branch to HALT_ADDR via a conditional branch behaves as a normal branch, not a halt.
- misaligned:
  - Set on any latched target with [1:0]!=0; the target is still taken unmodified.
  - Cleared only by reset.
- No combinational path from step to pc; pc changes only on a clk edge.

Decomposition:
- Shared package:
  - pc_state_t enum {RUN, DELAY, HALT_DS, HALTED}
  - PC_RESET_VECTOR and PC_HALT_ADDR constants, used as parameter defaults
  - PC_INCR = 32'd4
- One combinational sub-module, `pc_target_calc`:
  - Inputs: pc, branch_offset, jump_index, reg_target and the three qualifiers.
  - Outputs: redirect (1), target (32), is_halt_jump (1).
  - Keeps the FSM file purely sequential.

Test Plan:
- Reset then 3 steps with no control flow -> pc = BFC00000, BFC00004, BFC00008, BFC0000C; link_addr=BFC00014 at the end; active=1.
- pc=BFC00010, BEQ taken with branch_offset=FFFFFFF0, step; then step -> pc=BFC00014 with in_delay_slot=1, then pc=BFC00004. Same stimulus with branch_cond=0 -> BFC00014, BFC00018.
- JR with reg_target=0, step; then step -> pc=pc+4 with in_delay_slot=1, then pc=0, active=0. Further steps and redirects leave pc=0.
- Taken branch, then J in the delay slot -> ds_violation high exactly one cycle, pc goes to the branch target, not the J target.
- pc=FFFFFFFC, step -> pc=00000000 (wrap), active stays 1. JR to 80000002 -> misaligned=1 and stays 1 until reset.
- reset_n low asynchronously while in DELAY, mid-cycle -> pc=BFC00000 and in_delay_slot=0 immediately without a clock edge. After release, the next step gives pc=BFC00004.
